detector_jogada: RTL and testbench
==================================

Name: detector_jogada

Overview:
- Upstream input stage of the game's control unit. Watches the nine board-position buttons and debounces them.
- Accepts a press only while the control unit is waiting for a macro or micro play.
- On an accepted press, emits a one-cycle tem_jogada pulse plus the encoded position (0..8) that the control unit registers in registra_macro / registra_micro.
- Requires the button to be released, and stable, before the next play can be detected, so one press can never count as both the macro and the micro play.

Parameters:
- DEBOUNCE_CYCLES, default 1000: consecutive stable cycles required for both press and release (legal range >= 1).
- CNT_W, default 16: stability counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- habilita  input  1  play enable; driven by jogar_macro OR jogar_micro
- botoes  input  9  raw button levels, bit i = board position i, 1 = pressed
- tem_jogada  output  1  one-cycle pulse: valid play detected
- jogada  output  4  encoded position of the last accepted play (0..8), held until the next accepted play
- db_estado  output  4  debug: current state code

Behaviour:
- Single clock. Reset is synchronous and active-high (sampled on the rising clock edge).
- Reset values: state ESPERA, counter 0, captured vector 0, tem_jogada 0, jogada 0, db_estado 0.
- A reset asserted in any state returns the block to these values at the next edge, including mid-debounce and mid-release.
- Moore outputs:
  - tem_jogada = 1 only in EMITE.
  - db_estado = state code (ESPERA=0, ESTABILIZA=1, EMITE=2, AGUARDA_SOLTAR=3). Any illegal code goes to ESPERA with db_estado 0.
- "one-hot" means exactly one bit of botoes is set.
- ESPERA (0):
  - If habilita=1 and botoes is one-hot: capture botoes, clear the counter, go to ESTABILIZA.
  - Otherwise stay. Zero buttons or multiple buttons pressed are ignored.
- ESTABILIZA (1):
  - If habilita=0 or botoes differs from the captured vector: go to ESPERA.
  - Else if counter == DEBOUNCE_CYCLES-1: go to EMITE and load jogada with the index of the captured bit (bit i -> i).
  - Else increment the counter.
- EMITE (2):
  - Lasts exactly one cycle, then unconditionally goes to AGUARDA_SOLTAR. habilita is ignored here.
- AGUARDA_SOLTAR (3):
  - habilita is ignored.
  - If botoes != 0: clear the counter.
  - Else if counter == DEBOUNCE_CYCLES-1: go to ESPERA and clear the counter.
  - Else increment the counter.
- Latency: with the one-hot value first sampled at edge E0 and held through edges E1..ED, tem_jogada is high for the single cycle between edges ED and ED+1. jogada is valid in that same cycle.
- Holding a button indefinitely produces exactly one pulse.
- The control unit leaves joga_* on the edge after the pulse. The block never pulses twice for one press.
- Release needs DEBOUNCE_CYCLES consecutive all-zero samples. Any bounce restarts the release count.
- jogada changes only on entry to EMITE.
- No arithmetic overflow: the counter never exceeds DEBOUNCE_CYCLES-1.

Test Plan:
- (DEBOUNCE_CYCLES=4 for all tests.)
- Basic press: habilita=1, botoes=9'b000010000 held from edge E0 -> tem_jogada=1 for exactly the one cycle after edge E4, jogada=4; db_estado sequence 0,1,1,1,1,2,3.
- Bounce: botoes bit0 high 2 cycles, low 1 cycle, then high and stable -> no pulse during the bounce; single pulse 4 edges after the restart; jogada=0.
- Multiple buttons: botoes=9'b000000011 for 10 cycles with habilita=1 -> tem_jogada stays 0, db_estado stays 0, jogada unchanged.
- Enable gating: botoes=9'b100000000 held with habilita=0 for 8 cycles -> no pulse. Raise habilita -> pulse after 4 further edges, jogada=8. Keep the button held 20 more cycles -> no second pulse.
- Release then new play:
  - After the previous pulse, release with one bounce (0,1,0,0,0,0) -> returns to ESPERA only after 4 consecutive zeros.
  - Then press bit2 stable -> pulse, jogada=2.
- Reset mid-operation: assert reset for one cycle while in ESTABILIZA after a prior jogada=7 -> after that edge db_estado=0, tem_jogada=0, jogada=0. With the button still held and habilita=1, a fresh 4-cycle debounce then starts.

Source files
------------

// File: rtl/detector_jogada_if.sv
// Play-detector bus between the control unit and the button input stage.
//   habilita   : play enable (jogar_macro OR jogar_micro), control unit -> detector
//   botoes     : raw button levels, bit i = board position i, 1 = pressed
//   tem_jogada : one-cycle pulse, valid play detected
//   jogada     : encoded position (0..8) of the last accepted play
//   db_estado  : debug view of the detector state code
interface detector_jogada_if;
    logic       habilita;
    logic [8:0] botoes;
    logic       tem_jogada;
    logic [3:0] jogada;
    logic [3:0] db_estado;

    modport master (
        output habilita,
        output botoes,
        input  tem_jogada,
        input  jogada,
        input  db_estado
    );

    modport slave (
        input  habilita,
        input  botoes,
        output tem_jogada,
        output jogada,
        output db_estado
    );
endinterface

// File: rtl/detector_jogada.sv
// Button input stage of the game's control unit: debounces the nine board
// buttons, accepts a single one-hot press while plays are enabled, pulses
// tem_jogada for one cycle with the encoded position, then waits for a
// debounced release before another play can be detected.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : detector_jogada_if.slave (habilita, botoes in; tem_jogada,
//           jogada, db_estado out)
module detector_jogada #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic               clock,
    input  logic               reset,
    detector_jogada_if.slave   bus
);

    localparam int unsigned NUM_BOTOES = 9;
    localparam int unsigned JOGADA_W   = 4;
    localparam int unsigned ESTADO_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ESPERA         = 2'd0,
        ESTABILIZA     = 2'd1,
        EMITE          = 2'd2,
        AGUARDA_SOLTAR = 2'd3
    } estado_t;

    estado_t                 estado_q,  estado_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic [NUM_BOTOES-1:0]   capt_q,    capt_d;
    logic [JOGADA_W-1:0]     jogada_q,  jogada_d;
    logic                    tem_q,     tem_d;
    logic [ESTADO_W-1:0]     dbg_q,     dbg_d;

    logic                    one_hot_c;
    logic [JOGADA_W-1:0]     idx_c;

    // Exactly one button pressed.
    always_comb begin
        one_hot_c = (bus.botoes != '0) &&
                    ((bus.botoes & (bus.botoes - NUM_BOTOES'(1))) == '0);
    end

    // Position index of the captured (one-hot) vector.
    always_comb begin
        idx_c = '0;
        for (int i = 0; i < int'(NUM_BOTOES); i++) begin
            if (capt_q[i]) begin
                idx_c = JOGADA_W'(i);
            end
        end
    end

    // State register and registered Moore outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= ESPERA;
            cnt_q    <= '0;
            capt_q   <= '0;
            jogada_q <= '0;
            tem_q    <= 1'b0;
            dbg_q    <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            capt_q   <= capt_d;
            jogada_q <= jogada_d;
            tem_q    <= tem_d;
            dbg_q    <= dbg_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so the
    // registered copies always match the state register.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        capt_d   = capt_q;
        jogada_d = jogada_q;

        case (estado_q)
            ESPERA: begin
                if (bus.habilita && one_hot_c) begin
                    capt_d   = bus.botoes;
                    cnt_d    = '0;
                    estado_d = ESTABILIZA;
                end
            end
            ESTABILIZA: begin
                if (!bus.habilita || (bus.botoes != capt_q)) begin
                    estado_d = ESPERA;
                end else if (cnt_q == CNT_MAX) begin
                    jogada_d = idx_c;
                    estado_d = EMITE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            EMITE: begin
                // Counter still holds the press count; restart it so the
                // release needs a full run of zero samples.
                cnt_d    = '0;
                estado_d = AGUARDA_SOLTAR;
            end
            AGUARDA_SOLTAR: begin
                if (bus.botoes != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d    = '0;
                    estado_d = ESPERA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d    = '0;
                estado_d = ESPERA;
            end
        endcase

        tem_d = (estado_d == EMITE);
        dbg_d = ESTADO_W'(estado_d);
    end

    assign bus.tem_jogada = tem_q;
    assign bus.jogada     = jogada_q;
    assign bus.db_estado  = dbg_q;

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada with DEBOUNCE_CYCLES = 4.
module tb_detector_jogada;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    detector_jogada_if bus ();

    detector_jogada #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (16)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge; sample and drive 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Button vector already applied and first sampled at the next edge:
    // four debounce cycles, pulse in the cycle after the fifth edge.
    task automatic press_expect(input string tag, input logic [8:0] vec, input int exp_pos);
        bus.botoes = vec;
        for (int k = 0; k < 5; k++) begin
            tick();
            check({tag, "_tem"}, 32'(bus.tem_jogada), (k == 4) ? 32'd1 : 32'd0);
            check({tag, "_db"},  32'(bus.db_estado),  (k == 4) ? 32'd2 : 32'd1);
        end
        check({tag, "_jogada"}, 32'(bus.jogada), 32'(exp_pos));
    endtask

    // Release right after the pulse cycle: one edge into AGUARDA_SOLTAR,
    // then four zero samples back to ESPERA.
    task automatic release_after_pulse(input string tag);
        bus.botoes = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check({tag, "_tem"}, 32'(bus.tem_jogada), 32'd0);
            check({tag, "_db"},  32'(bus.db_estado), (k == 4) ? 32'd0 : 32'd3);
        end
    endtask

    initial begin
        int exp_rel[6];
        logic [8:0] rel_pat[6];

        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        bus.habilita = 1'b0;
        bus.botoes   = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_tem", 32'(bus.tem_jogada), 32'd0);
        check("rst_jogada", 32'(bus.jogada), 32'd0);
        check("rst_db", 32'(bus.db_estado), 32'd0);

        // Basic press on position 4, held well past the pulse.
        bus.habilita = 1'b1;
        press_expect("basic", 9'b000010000, 4);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("hold_tem", 32'(bus.tem_jogada), 32'd0);
            check("hold_db", 32'(bus.db_estado), 32'd3);
        end

        // Release with one bounce: 0,1,0,0,0,0.
        rel_pat = '{9'd0, 9'b000010000, 9'd0, 9'd0, 9'd0, 9'd0};
        exp_rel = '{3, 3, 3, 3, 3, 0};
        for (int k = 0; k < 6; k++) begin
            bus.botoes = rel_pat[k];
            tick();
            check("rel_bounce_db", 32'(bus.db_estado), 32'(exp_rel[k]));
            check("rel_bounce_tem", 32'(bus.tem_jogada), 32'd0);
        end

        // Two buttons at once are ignored.
        bus.botoes = 9'b000000011;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("multi_tem", 32'(bus.tem_jogada), 32'd0);
            check("multi_db", 32'(bus.db_estado), 32'd0);
        end
        check("multi_jogada", 32'(bus.jogada), 32'd4);

        // Press bounce on bit 0: high 2, low 1, then stable.
        bus.botoes = '0;
        tick();
        bus.botoes = 9'b000000001;
        tick();
        check("bnc_db0", 32'(bus.db_estado), 32'd1);
        tick();
        check("bnc_db1", 32'(bus.db_estado), 32'd1);
        bus.botoes = '0;
        tick();
        check("bnc_db2", 32'(bus.db_estado), 32'd0);
        check("bnc_tem", 32'(bus.tem_jogada), 32'd0);
        press_expect("bounce", 9'b000000001, 0);
        release_after_pulse("bnc_rel");

        // Enable gating on position 8.
        bus.habilita = 1'b0;
        bus.botoes   = 9'b100000000;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("gate_tem", 32'(bus.tem_jogada), 32'd0);
            check("gate_db", 32'(bus.db_estado), 32'd0);
        end
        bus.habilita = 1'b1;
        press_expect("gate", 9'b100000000, 8);
        for (int k = 0; k < 20; k++) begin
            tick();
            check("gate_hold_tem", 32'(bus.tem_jogada), 32'd0);
        end
        check("gate_hold_jogada", 32'(bus.jogada), 32'd8);
        bus.botoes = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("gate_rel_db", 32'(bus.db_estado), (k == 3) ? 32'd0 : 32'd3);
        end

        // New play on position 2 after release.
        press_expect("bit2", 9'b000000100, 2);
        release_after_pulse("bit2_rel");

        // Play on 7, then reset mid-debounce of the next press.
        press_expect("bit7", 9'b010000000, 7);
        release_after_pulse("bit7_rel");
        bus.botoes = 9'b010000000;
        tick();
        tick();
        check("pre_rst_db", 32'(bus.db_estado), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_db", 32'(bus.db_estado), 32'd0);
        check("mid_rst_tem", 32'(bus.tem_jogada), 32'd0);
        check("mid_rst_jogada", 32'(bus.jogada), 32'd0);
        press_expect("post_rst", 9'b010000000, 7);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
